// File: rtl/adc_spi_ctrl.sv
// SPI master for the 8-channel 12-bit serial ADC: one frame per accepted start, result returned with a one-cycle valid.
// Start-to-valid latency is 1+33*CLK_DIV clk cycles; starts arriving while busy are dropped, not queued.
module adc_spi_ctrl #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_QUIET = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  chan,
    output logic        busy,
    output logic        data_valid,
    output logic [11:0] data,
    output logic [2:0]  data_chan,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_din,
    input  logic        adc_dout
);

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] QUIET_LAST = 8'(CS_QUIET - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_QUIET
    } state_t;

    state_t      state_q;
    logic [7:0]  hcnt_q;
    logic [4:0]  ecnt_q;
    logic [7:0]  ctrl_q;
    logic [11:0] sr_q;
    logic [2:0]  chan_q;
    logic        cs_n_q;
    logic        sclk_q;
    logic        din_q;
    logic        busy_q;
    logic        vld_q;
    logic [11:0] data_q;
    logic [2:0]  dchan_q;
    logic        half_done;

    assign half_done = (hcnt_q == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hcnt_q  <= 8'd0;
            ecnt_q  <= 5'd0;
            ctrl_q  <= 8'd0;
            sr_q    <= 12'd0;
            chan_q  <= 3'd0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            din_q   <= 1'b0;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
            data_q  <= 12'd0;
            dchan_q <= 3'd0;
        end else begin
            vld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        chan_q  <= chan;
                        ctrl_q  <= {2'b00, chan, 3'b000};
                        sr_q    <= 12'd0;
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        hcnt_q  <= 8'd0;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (half_done) begin
                        hcnt_q  <= 8'd0;
                        ecnt_q  <= 5'd0;
                        sclk_q  <= 1'b0;
                        din_q   <= ctrl_q[7];
                        ctrl_q  <= {ctrl_q[6:0], 1'b0};
                        state_q <= S_SHIFT;
                    end else begin
                        hcnt_q <= hcnt_q + 8'd1;
                    end
                end
                S_SHIFT: begin
                    // ecnt_q is the index of the last SCLK edge issued; falling edge 1 is index 0
                    if (half_done) begin
                        hcnt_q <= 8'd0;
                        ecnt_q <= ecnt_q + 5'd1;
                        sclk_q <= ~sclk_q;
                        if (sclk_q) begin
                            din_q  <= ctrl_q[7];
                            ctrl_q <= {ctrl_q[6:0], 1'b0};
                        end else begin
                            if (ecnt_q >= 5'd8) begin
                                sr_q <= {sr_q[10:0], adc_dout};
                            end
                            if (ecnt_q == 5'd30) begin
                                state_q <= S_HOLD;
                            end
                        end
                    end else begin
                        hcnt_q <= hcnt_q + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (half_done) begin
                        cs_n_q  <= 1'b1;
                        data_q  <= sr_q;
                        dchan_q <= chan_q;
                        vld_q   <= 1'b1;
                        if (CS_QUIET == 1) begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            hcnt_q  <= 8'd1;
                            state_q <= S_QUIET;
                        end
                    end else begin
                        hcnt_q <= hcnt_q + 8'd1;
                    end
                end
                S_QUIET: begin
                    // the quiet count includes the cycle in which cs_n rose
                    if (hcnt_q == QUIET_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        hcnt_q <= hcnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign data_valid = vld_q;
    assign data       = data_q;
    assign data_chan  = dchan_q;
    assign adc_cs_n   = cs_n_q;
    assign adc_sclk   = sclk_q;
    assign adc_din    = din_q;

endmodule

// File: tb/tb_adc_spi_ctrl.sv
// Bench for adc_spi_ctrl: ADC model on the SPI pins, frame-position reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_adc_spi_ctrl;

    localparam int H = 4;
    localparam int Q = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  chan = 3'd0;
    logic        busy;
    logic        data_valid;
    logic [11:0] data;
    logic [2:0]  data_chan;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        adc_din;
    logic        adc_dout = 1'b0;

    always #5 clk = ~clk;

    adc_spi_ctrl #(.CLK_DIV(H), .CS_QUIET(Q)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .chan       (chan),
        .busy       (busy),
        .data_valid (data_valid),
        .data       (data),
        .data_chan  (data_chan),
        .adc_cs_n   (adc_cs_n),
        .adc_sclk   (adc_sclk),
        .adc_din    (adc_din),
        .adc_dout   (adc_dout)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int t0 = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Analog inputs seen by the ADC: fixed level per channel, channel 0 plays a sequence.
    logic [11:0] chan_val [8];
    logic [11:0] ch0_seq  [2];
    initial begin
        chan_val[0] = 12'h000; chan_val[1] = 12'h400; chan_val[2] = 12'hC00; chan_val[3] = 12'h5A5;
        chan_val[4] = 12'h3C3; chan_val[5] = 12'h600; chan_val[6] = 12'h0F0; chan_val[7] = 12'h100;
        ch0_seq[0]  = 12'hABC; ch0_seq[1]  = 12'h123;
    end

    // ADC model: address from DIN at falling edges 3..5, result driven MSB first from falling edge 5.
    int          adc_fall = 0;
    int          adc_pop = 0;
    logic [2:0]  adc_addr = 3'd0;
    logic [11:0] adc_smp = 12'd0;
    always @(negedge adc_sclk or posedge adc_cs_n) begin
        if (adc_cs_n === 1'b1) begin
            adc_fall = 0;
            adc_dout = 1'b0;
        end else begin
            #1;
            adc_fall++;
            if (adc_fall >= 3 && adc_fall <= 5) adc_addr = {adc_addr[1:0], adc_din};
            if (adc_fall == 5) begin
                if (adc_addr == 3'd0) begin
                    adc_smp = (adc_pop < 2) ? ch0_seq[adc_pop] : 12'h000;
                    adc_pop++;
                end else begin
                    adc_smp = chan_val[adc_addr];
                end
            end
            adc_dout = (adc_fall >= 5 && adc_fall <= 16) ? adc_smp[16 - adc_fall] : 1'b0;
        end
    end

    // Reference model: outputs as a function of the position p (clk edges since the accepting edge).
    bit          m_ok = 1'b0;
    bit          m_act = 1'b0;
    int          p = 0;
    int          half = 0;
    int          kk = 0;
    int          m_pop = 0;
    logic [2:0]  m_chan = 3'd0;
    logic [7:0]  m_ctrl = 8'd0;
    logic [11:0] m_smp = 12'd0;
    logic        m_cs_n = 1'b1, m_sclk = 1'b1, m_din = 1'b0, m_busy = 1'b0, m_vld = 1'b0;
    logic [11:0] m_data = 12'd0;
    logic [2:0]  m_dchan = 3'd0;

    always @(posedge clk) begin
        if (rst_n === 1'b0) begin
            m_ok = 1'b1; m_act = 1'b0; m_data = 12'd0; m_dchan = 3'd0;
        end else if (m_ok) begin
            if (m_act) begin
                p++;
            end else if (start === 1'b1) begin
                m_act = 1'b1; p = 0; m_chan = chan; m_ctrl = {2'b00, chan, 3'b000};
                if (chan == 3'd0) begin
                    m_smp = (m_pop < 2) ? ch0_seq[m_pop] : 12'h000;
                    m_pop++;
                end else begin
                    m_smp = chan_val[chan];
                end
            end
        end
        m_vld = 1'b0;
        if (m_act) begin
            m_cs_n = (p >= 33 * H);
            m_busy = (p <= 33 * H + Q - 2);
            if (p < H || p >= 33 * H) begin
                m_sclk = 1'b1;
                m_din  = 1'b0;
            end else begin
                half   = (p - H) / H;
                m_sclk = (half % 2) == 1;
                kk     = half / 2 + 1;
                m_din  = (kk <= 8) ? m_ctrl[8 - kk] : 1'b0;
            end
            if (p == 33 * H) begin
                m_vld = 1'b1; m_data = m_smp; m_dchan = m_chan;
            end
            if (p == 33 * H + Q - 1) m_act = 1'b0;
        end else begin
            m_cs_n = 1'b1; m_sclk = 1'b1; m_din = 1'b0; m_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("cs_n", adc_cs_n, m_cs_n);
            check("sclk", adc_sclk, m_sclk);
            check("din", adc_din, m_din);
            check("busy", busy, m_busy);
            check("data_valid", data_valid, m_vld);
            check("data", data, m_data);
            check("data_chan", data_chan, m_dchan);
        end
    end

    // Pin-level monitor: run lengths of cs_n, DIN per falling edge, DIN stability at rising edges.
    logic        pv_sclk = 1'b1, pv_cs_n = 1'b1, pv_din = 1'b0;
    int          lo_run = 0, hi_run = 0, last_lo = 0, last_gap = 0;
    int          n_falls = 0, n_vld = 0, fall_idx = 0, rise_viol = 0;
    logic [15:0] dfall = 16'd0;
    always @(negedge clk) begin
        if (adc_cs_n === 1'b0) begin
            if (pv_cs_n === 1'b1) begin
                last_gap = hi_run; hi_run = 0; lo_run = 1; n_falls++; fall_idx = 0; dfall = 16'd0;
            end else lo_run++;
        end else begin
            if (pv_cs_n === 1'b0) begin
                last_lo = lo_run; lo_run = 0; hi_run = 1;
            end else hi_run++;
        end
        if (pv_sclk === 1'b1 && adc_sclk === 1'b0 && adc_cs_n === 1'b0) begin
            fall_idx++;
            if (fall_idx <= 16) dfall[16 - fall_idx] = adc_din;
        end
        if (pv_sclk === 1'b0 && adc_sclk === 1'b1 && adc_din !== pv_din) rise_viol++;
        if (data_valid === 1'b1) n_vld++;
        pv_sclk = adc_sclk; pv_cs_n = adc_cs_n; pv_din = adc_din;
    end

    task automatic wait_vld(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (data_valid === 1'b1) seen = 1'b1;
        end
        #1;
        check({name, " valid seen"}, seen, 1'b1);
    endtask

    task automatic wait_fall(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (adc_cs_n === 1'b0) seen = 1'b1;
        end
        #1;
        check({name, " cs_n fall seen"}, seen, 1'b1);
    endtask

    task automatic wait_idle(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (busy === 1'b0) seen = 1'b1;
        end
        #1;
        check({name, " idle seen"}, seen, 1'b1);
    endtask

    task automatic kick(input logic [2:0] ch);
        @(negedge clk); #1;
        start = 1'b1; chan = ch; t0 = cyc;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    int v0, f0;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst cs_n", adc_cs_n, 1'b1);
        check("rst sclk", adc_sclk, 1'b1);
        check("rst din", adc_din, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst valid", data_valid, 1'b0);
        check("rst data", data, 12'h000);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // single conversion, channel 5
        kick(3'd5);
        wait_vld("t1");
        check("t1 valid cycle", cyc - t0, 133);
        check("t1 data", data, 12'h600);
        check("t1 chan", data_chan, 3'd5);
        check("t1 cs_n low cycles", last_lo, 132);
        wait_idle("t1");

        // back-to-back with start held high
        @(negedge clk); #1;
        chan = 3'd1; start = 1'b1;
        wait_fall("t2 f1");
        chan = 3'd2;
        wait_vld("t2 v1");
        check("t2 data1", data, 12'h400);
        check("t2 chan1", data_chan, 3'd1);
        wait_fall("t2 f2");
        check("t2 gap1", last_gap, Q);
        chan = 3'd7;
        wait_vld("t2 v2");
        check("t2 data2", data, 12'hC00);
        wait_fall("t2 f3");
        check("t2 gap2", last_gap, Q);
        start = 1'b0;
        wait_vld("t2 v3");
        check("t2 data3", data, 12'h100);
        check("t2 chan3", data_chan, 3'd7);
        wait_idle("t2");

        // control byte on DIN for channel 3
        kick(3'd3);
        wait_vld("t3");
        check("t3 din at falls", dfall, 16'h1800);
        check("t3 fall count", fall_idx, 16);
        check("t3 data", data, 12'h5A5);
        check("t3 din moved at rise", rise_viol, 0);
        wait_idle("t3");

        // channel 0 follows a changing input
        kick(3'd0);
        wait_vld("t4a");
        check("t4 data a", data, 12'hABC);
        wait_idle("t4a");
        kick(3'd0);
        wait_vld("t4b");
        check("t4 data b", data, 12'h123);
        check("t4 chan b", data_chan, 3'd0);
        wait_idle("t4b");

        // start during a frame is dropped
        v0 = n_vld; f0 = n_falls;
        kick(3'd6);
        repeat (38) @(negedge clk);
        #1;
        start = 1'b1; chan = 3'd1;
        @(negedge clk); #1;
        start = 1'b0;
        check("t5 busy during frame", busy, 1'b1);
        wait_vld("t5");
        check("t5 data", data, 12'h0F0);
        check("t5 chan", data_chan, 3'd6);
        wait_idle("t5");
        repeat (150) @(negedge clk);
        #1;
        check("t5 valid pulses", n_vld - v0, 1);
        check("t5 frames", n_falls - f0, 1);

        // reset on the edge that would raise SCLK for the 10th time
        v0 = n_vld;
        kick(3'd4);
        repeat (79) @(negedge clk);
        #1;
        check("t6 sclk low before rise10", adc_sclk, 1'b0);
        rst_n = 1'b0;
        @(negedge clk); #1;
        check("t6 cs_n", adc_cs_n, 1'b1);
        check("t6 sclk", adc_sclk, 1'b1);
        check("t6 busy", busy, 1'b0);
        check("t6 valid", data_valid, 1'b0);
        check("t6 data cleared", data, 12'h000);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        #1;
        check("t6 no valid after abort", n_vld - v0, 0);
        kick(3'd2);
        wait_vld("t6");
        check("t6 data", data, 12'hC00);
        check("t6 chan", data_chan, 3'd2);
        wait_idle("t6");
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_spi_ctrl.md
Name: adc_spi_ctrl

Overview:
- Synthesizable SPI master for the 8-channel, 12-bit serial ADC on the demodulator board.
- Drives adc_cs_n, adc_sclk and adc_din, and shifts in adc_dout.
- Returns one 12-bit sample per requested conversion to the demodulator datapath with a single-cycle valid strobe.
- It is the controller-side counterpart of the ADC, and its frames are what the bench ADC model responds to.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period; legal range 2..255.
- CS_QUIET, 8, minimum clk cycles adc_cs_n stays high between frames; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  conversion request; sampled only when busy=0.
- chan  in  3  channel to convert; captured with start.
- busy  out  1  high from the cycle after start is accepted until the quiet time ends.
- data_valid  out  1  one-clk pulse when data/data_chan are updated.
- data  out  12  last conversion result.
- data_chan  out  3  channel of the last result.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_sclk  out  1  ADC serial clock; idles high.
- adc_din  out  1  control bits to the ADC.
- adc_dout  in  1  serial data from the ADC.

Behaviour:
- Reset, applied on any clk edge with rst_n=0, including mid-frame. Next-cycle values:
  - adc_cs_n=1, adc_sclk=1, adc_din=0.
  - busy=0, data_valid=0, data=0, data_chan=0.
  - State returns to IDLE. An aborted frame never produces data_valid.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> QUIET -> IDLE.
- IDLE: on start=1, capture chan and build ctrl byte = {2'b00, chan, 3'b000}. Next cycle: adc_cs_n=0, busy=1, state SETUP.
- SETUP: hold adc_sclk=1 for CLK_DIV cycles, then enter SHIFT.
- SHIFT: 16 SCLK periods, numbered k=1..16.
  - Each period is a falling edge followed by a rising edge CLK_DIV cycles later. The next falling edge comes CLK_DIV cycles after that rising edge.
  - adc_din changes only with a falling SCLK edge. At falling edge k, k=1..8, adc_din=ctrl[8-k] (MSB first). From falling edge 9 onward, adc_din=0.
  - adc_dout is sampled on the clk edge that drives adc_sclk 0->1, for rising edges k=5..16 only. Bits fill the shift register MSB first. Rising edges 1..4 are leading zeros and are ignored.
  - The channel address applies to the same frame: the sample returned belongs to the chan captured at start.
- HOLD: after rising edge 16, keep adc_sclk=1 and adc_cs_n=0 for CLK_DIV cycles. Then, on the same cycle:
  - adc_cs_n=1
  - data=shift register
  - data_chan=captured chan
  - data_valid=1 for exactly one cycle.
- QUIET: adc_cs_n stays high for CS_QUIET cycles. busy deasserts on the last quiet cycle, and IDLE may accept a new start on the following edge.
- Timing, with H=CLK_DIV and start accepted at edge T0:
  - adc_cs_n falls at T0+1.
  - First falling SCLK edge at T0+1+H.
  - Rising edge 16 at T0+1+32H.
  - adc_cs_n rises and data_valid fires at T0+1+33H. For H=4 this is cycle 133.
- start while busy=1 is ignored, not queued. chan changes during a frame have no effect.
- A start held high continuously yields back-to-back frames separated by exactly CS_QUIET cycles of adc_cs_n high.
- adc_sclk never toggles while adc_cs_n=1. adc_cs_n never changes while adc_sclk=0.
- Counters: half-period counter 8 bits, wrapping at CLK_DIV-1. Edge counter 5 bits, 0..31. No overflow is possible with legal parameters.

Test Plan:
- chan=5, CLK_DIV=4, ADC model attached -> data=12'h600, data_chan=5, single data_valid at cycle 133 after start, adc_cs_n low for 132 cycles.
- chan=1, 2, 7 back-to-back with start held high -> data=12'h400, 12'hC00, 12'h100 in order; adc_cs_n high exactly CS_QUIET=8 cycles between frames.
- chan=3 -> adc_din at falling edges 1..8 equals 0,0,0,1,1,0,0,0; adc_din=0 after that; adc_din stable across every rising SCLK edge.
- chan=0 with the model fed signal samples 12'hABC then 12'h123 -> two frames return 12'hABC then 12'h123.
- start pulsed again at cycle 40 of a frame -> ignored: exactly one data_valid, busy stays high, no second frame.
- rst_n=0 for one cycle at rising edge 10 of a frame -> next cycle adc_cs_n=1, adc_sclk=1, busy=0, no data_valid; a following start with chan=2 returns 12'hC00 correctly.
